ula_sequencer: RTL and testbench
================================

Name: ula_sequencer

Overview:
- Multi-cycle command sequencer that drives the combinational 64-bit two's-complement ALU (`ula`) as its initiator.
- Accepts one arithmetic/compare command per handshake and presents the operands and op code to the ALU on registered outputs.
- Samples the ALU's result and overflow flag, then returns them to the requester with a one-cycle done pulse.
- Supports chaining: operand A can be the previous result, so datapath/test controllers can run accumulate sequences without external storage.

Parameters:
- BITS, 63: MSB index of all data buses (data width = BITS+1).
- OP_SUB, 2'b00: ALU op code for subtract.
- OP_ADD, 2'b01: ALU op code for add.
- OP_EQU, 2'b10: ALU op code for equality compare.
- OP_SLT, 2'b11: ALU op code for signed less-than.

Ports:
- clock  in  1  Single clock; all state changes on its rising edge.
- reset  in  1  Synchronous, active-high reset.
- start  in  1  Command valid; accepted only when pronto=1.
- pronto  out  1  Ready; high only in IDLE.
- cmd_op  in  2  Requested operation (OP_* codes).
- cmd_a  in  BITS+1  Operand A, signed.
- cmd_b  in  BITS+1  Operand B, signed.
- use_prev  in  1  When 1, operand A is taken from the previous result and cmd_a is ignored.
- clr_ovf  in  1  Clears ovf_sticky.
- ula_a  out  BITS+1  Registered operand A to the ALU.
- ula_b  out  BITS+1  Registered operand B to the ALU.
- ula_op  out  2  Registered op code to the ALU.
- ula_result  in  BITS+1  ALU result.
- ula_v  in  1  ALU overflow flag.
- result  out  BITS+1  Captured result; held until the next capture.
- overflow  out  1  Captured overflow of the last command.
- ovf_sticky  out  1  OR of the overflow flags of all commands since reset or clr_ovf.
- done  out  1  One-cycle pulse when result and overflow are valid.

Behaviour:
- States: IDLE, ISSUE, CAPTURE, DONE.
- Reset (synchronous, on any clock edge with reset=1, from any state):
  - State goes to IDLE.
  - ula_a, ula_b, result and the previous-result register are set to 0.
  - ula_op is set to OP_ADD.
  - overflow, ovf_sticky and done are set to 0.
  - pronto is 1.
  - A command in flight is discarded; no done is produced for it.
- IDLE:
  - pronto=1.
  - If start=1 on an edge, the command is accepted. At that same edge:
    - ula_a is loaded with the previous result if use_prev=1, otherwise with cmd_a.
    - ula_b is loaded with cmd_b and ula_op with cmd_op.
    - State goes to ISSUE.
  - If start=0, state stays IDLE.
- ISSUE:
  - One cycle so the ALU's combinational path settles. Next state is CAPTURE.
- CAPTURE, at its edge:
  - result and the previous-result register are loaded with ula_result.
  - overflow is loaded with ula_v if ula_op is OP_ADD or OP_SUB, otherwise with 0.
  - ovf_sticky |= that overflow value.
  - Next state is DONE.
- DONE:
  - done=1 for exactly this cycle. Next state is IDLE.
- Latency: accept edge at cycle 0, done high during cycle 3. Back-to-back throughput is one command per 4 cycles.
- start while pronto=0 is ignored, not queued. cmd_* inputs are only sampled at the accept edge.
- ula_* outputs hold their values until the next accept.
- use_prev before any command has completed uses 0.
- clr_ovf has priority over a same-cycle capture: ovf_sticky ends at 0. overflow itself is still updated.
- EQU/SLT results are 0 or 1, zero-extended, taken exactly as the ALU returns them.
- No arithmetic is done inside this block; the operand width is passed through unchanged.

Test Plan:
- Reset, then start with ADD, a=5, b=7 → pronto drops for 3 cycles; done in cycle 3; result=12, overflow=0.
- ADD with a=64'h7FFF_FFFF_FFFF_FFFF, b=1 → result=64'h8000_0000_0000_0000, overflow=1, ovf_sticky=1. Then clr_ovf=1 → ovf_sticky=0.
- SUB with a=3, b=10 → result=-7 (64'hFFFF_FFFF_FFFF_FFF9). Then use_prev=1, ADD with b=7 → ula_a=-7, result=0.
- EQU with a=b=42 → result=1, overflow=0 even if the ALU model forces ula_v=1. SLT with a=-1, b=0 → result=1.
- start held high continuously with 4 different commands → exactly one done per 4 cycles; commands presented while pronto=0 are not executed.
- Assert reset during CAPTURE → no done pulse; result=0; pronto=1 the next cycle; a use_prev command then sees A=0.

Source files
------------

// File: rtl/ula_sequencer_if.sv
// Command/response and ALU-side bus of the ula sequencer.
// master = requester plus ALU, slave = sequencer.
interface ula_sequencer_if #(
  parameter int BITS = 63
);
  logic            start;
  logic            pronto;
  logic [1:0]      cmd_op;
  logic [BITS:0]   cmd_a;
  logic [BITS:0]   cmd_b;
  logic            use_prev;
  logic            clr_ovf;
  logic [BITS:0]   ula_a;
  logic [BITS:0]   ula_b;
  logic [1:0]      ula_op;
  logic [BITS:0]   ula_result;
  logic            ula_v;
  logic [BITS:0]   result;
  logic            overflow;
  logic            ovf_sticky;
  logic            done;

  modport master (
    output start, cmd_op, cmd_a, cmd_b,
    output use_prev, clr_ovf,
    output ula_result, ula_v,
    input  pronto, ula_a, ula_b, ula_op,
    input  result, overflow, ovf_sticky, done
  );

  modport slave (
    input  start, cmd_op, cmd_a, cmd_b,
    input  use_prev, clr_ovf,
    input  ula_result, ula_v,
    output pronto, ula_a, ula_b, ula_op,
    output result, overflow, ovf_sticky, done
  );
endinterface

// File: rtl/ula_sequencer.sv
// Multi-cycle command sequencer driving a combinational ALU.
// Issue, let the ALU settle, capture, then pulse done.
module ula_sequencer #(
  parameter int         BITS   = 63,
  parameter logic [1:0] OP_SUB = 2'b00,
  parameter logic [1:0] OP_ADD = 2'b01,
  parameter logic [1:0] OP_EQU = 2'b10,
  parameter logic [1:0] OP_SLT = 2'b11
) (
  input logic            clock,
  input logic            reset,
  ula_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [BITS:0] prev;
  logic          accept;
  logic          capture;
  logic          cap_ovf;
  logic          arith;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    capture    = 1'b0;
    bus.pronto = 1'b0;
    bus.done   = 1'b0;
    unique case (state)
      IDLE: begin
        bus.pronto = 1'b1;
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Compare ops never report overflow, whatever the ALU flag says.
  assign arith   = (bus.ula_op == OP_ADD) ||
                   (bus.ula_op == OP_SUB);
  assign cap_ovf = arith & bus.ula_v;

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.ula_a      <= '0;
      bus.ula_b      <= '0;
      bus.ula_op     <= OP_ADD;
      bus.result     <= '0;
      prev           <= '0;
      bus.overflow   <= 1'b0;
      bus.ovf_sticky <= 1'b0;
    end else begin
      if (accept) begin
        bus.ula_a  <= bus.use_prev ? prev : bus.cmd_a;
        bus.ula_b  <= bus.cmd_b;
        bus.ula_op <= bus.cmd_op;
      end
      if (capture) begin
        bus.result   <= bus.ula_result;
        prev         <= bus.ula_result;
        bus.overflow <= cap_ovf;
      end
      if (bus.clr_ovf)
        bus.ovf_sticky <= 1'b0;
      else if (capture)
        bus.ovf_sticky <= bus.ovf_sticky | cap_ovf;
    end
  end

endmodule

// File: tb/tb_ula_sequencer.sv
// Scoreboard bench for ula_sequencer with a behavioural ALU.
// Expected responses are queued at issue and popped on done.
module tb_ula_sequencer;

  localparam logic [1:0] OP_SUB = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_EQU = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  typedef struct {
    logic [63:0] r;
    logic        o;
    logic        s;
  } exp_t;

  logic clock;
  logic reset;
  logic force_v;
  int   compared;
  int   mismatched;
  int   done_cnt;
  exp_t q[$];

  ula_sequencer_if #(.BITS(63)) bus ();

  ula_sequencer #(
    .BITS(63),
    .OP_SUB(OP_SUB),
    .OP_ADD(OP_ADD),
    .OP_EQU(OP_EQU),
    .OP_SLT(OP_SLT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU; force_v lets the bench inject a bogus flag.
  logic [63:0] alu_sum;
  logic [63:0] alu_dif;
  always_comb begin
    alu_sum = bus.ula_a + bus.ula_b;
    alu_dif = bus.ula_a - bus.ula_b;
    bus.ula_result = '0;
    bus.ula_v = 1'b0;
    case (bus.ula_op)
      OP_SUB: begin
        bus.ula_result = alu_dif;
        bus.ula_v = (bus.ula_a[63] != bus.ula_b[63]) &&
                    (alu_dif[63] != bus.ula_a[63]);
      end
      OP_ADD: begin
        bus.ula_result = alu_sum;
        bus.ula_v = (bus.ula_a[63] == bus.ula_b[63]) &&
                    (alu_sum[63] != bus.ula_a[63]);
      end
      OP_EQU:
        bus.ula_result = {63'd0, bus.ula_a == bus.ula_b};
      default:
        bus.ula_result = {63'd0,
          $signed(bus.ula_a) < $signed(bus.ula_b)};
    endcase
    bus.ula_v = bus.ula_v | force_v;
  end

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (bus.done) begin
      exp_t e;
      done_cnt++;
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got result %h expected no done",
                 bus.result);
      end else begin
        e = q.pop_front();
        chk("result", bus.result, e.r);
        chk("overflow", 64'(bus.overflow), 64'(e.o));
        chk("ovf_sticky", 64'(bus.ovf_sticky), 64'(e.s));
      end
    end
  end

  task automatic issue(logic [1:0] op, logic [63:0] a,
                       logic [63:0] b, logic up,
                       logic [63:0] er, logic eo, logic es);
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.pronto && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.pronto) chk("pronto_timeout", 64'(bus.pronto), 64'd1);
    bus.start = 1'b1;
    bus.cmd_op = op;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.use_prev = up;
    q.push_back('{er, eo, es});
    @(negedge clock);
    bus.start = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(posedge clock);
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  initial begin
    int d0;
    compared = 0;
    mismatched = 0;
    done_cnt = 0;
    force_v = 1'b0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.cmd_op = OP_SUB;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.use_prev = 1'b0;
    bus.clr_ovf = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_pronto", 64'(bus.pronto), 64'd1);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_ula_a", bus.ula_a, 64'd0);
    chk("rst_ula_op", 64'(bus.ula_op), 64'(OP_ADD));
    chk("rst_sticky", 64'(bus.ovf_sticky), 64'd0);
    reset = 1'b0;

    // ADD 5+7 with latency / pronto profile check
    @(negedge clock);
    bus.start = 1'b1;
    bus.cmd_op = OP_ADD;
    bus.cmd_a = 64'd5;
    bus.cmd_b = 64'd7;
    q.push_back('{64'd12, 1'b0, 1'b0});
    @(negedge clock);
    bus.start = 1'b0;
    chk("c1_pronto", 64'(bus.pronto), 64'd0);
    chk("c1_done", 64'(bus.done), 64'd0);
    @(negedge clock);
    chk("c2_pronto", 64'(bus.pronto), 64'd0);
    chk("c2_done", 64'(bus.done), 64'd0);
    @(negedge clock);
    chk("c3_pronto", 64'(bus.pronto), 64'd0);
    chk("c3_done", 64'(bus.done), 64'd1);
    @(negedge clock);
    chk("c4_pronto", 64'(bus.pronto), 64'd1);
    chk("c4_done", 64'(bus.done), 64'd0);

    issue(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
          64'h8000_0000_0000_0000, 1'b1, 1'b1);
    @(negedge clock);
    bus.clr_ovf = 1'b1;
    @(negedge clock);
    bus.clr_ovf = 1'b0;
    chk("clr_sticky", 64'(bus.ovf_sticky), 64'd0);
    chk("clr_keeps_ovf", 64'(bus.overflow), 64'd1);

    issue(OP_SUB, 64'd3, 64'd10, 1'b0,
          64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0);
    issue(OP_ADD, 64'd123, 64'd7, 1'b1, 64'd0, 1'b0, 1'b0);
    chk("prev_ula_a", bus.ula_a, 64'hFFFF_FFFF_FFFF_FFF9);
    chk("hold_ula_b", bus.ula_b, 64'd7);

    force_v = 1'b1;
    issue(OP_EQU, 64'd42, 64'd42, 1'b0, 64'd1, 1'b0, 1'b0);
    force_v = 1'b0;
    issue(OP_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0,
          64'd1, 1'b0, 1'b0);
    issue(OP_SLT, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
          64'd0, 1'b0, 1'b0);

    // clr_ovf held across a capture that flags overflow
    force_v = 1'b1;
    bus.clr_ovf = 1'b1;
    issue(OP_SUB, 64'd10, 64'd3, 1'b0, 64'd7, 1'b1, 1'b0);
    force_v = 1'b0;
    bus.clr_ovf = 1'b0;

    // start held high: only commands seen while pronto=1 run
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      bus.start = 1'b1;
      bus.cmd_op = OP_ADD;
      bus.cmd_a = 64'(i * 100);
      bus.cmd_b = 64'(i);
      bus.use_prev = 1'b0;
      if (bus.pronto) q.push_back('{64'(i * 101), 1'b0, 1'b0});
    end
    @(negedge clock);
    bus.start = 1'b0;
    repeat (6) @(negedge clock);
    chk("burst_dones", 64'(done_cnt - d0), 64'd4);
    chk("burst_queue", 64'(q.size()), 64'd0);
    q.delete();

    // reset while in CAPTURE discards the command
    @(negedge clock);
    bus.start = 1'b1;
    bus.cmd_op = OP_ADD;
    bus.cmd_a = 64'd1;
    bus.cmd_b = 64'd2;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    chk("pre_rst_pronto", 64'(bus.pronto), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_result", bus.result, 64'd0);
    chk("mid_rst_pronto", 64'(bus.pronto), 64'd1);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    repeat (3) @(negedge clock);
    issue(OP_ADD, 64'd55, 64'd9, 1'b1, 64'd9, 1'b0, 1'b0);
    chk("rst_prev_ula_a", bus.ula_a, 64'd0);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
